fp_mul_sched: RTL and testbench
===============================

// Module: fp_mul_sched
// PURPOSE
//   Shares one signed fixed-point multiplier among N_REQ requesters.
//   Each requester supplies A (Q format NB_A/NBF_A), B (NB_B/NBF_B) and a quantization mode.
//   The block arbitrates round-robin and runs a 3-stage pipeline: grant, full-res multiply, quantize.
//   It returns one NB_OUT/NBF_OUT result per cycle, tagged with the requester id.
//   Sits between the filter/datapath control sequencers and the shared multiplier resource.
// PARAMETERS
//   N_REQ    4   number of requesters (>=2)
//   NB_A     16  total bits of operand A;  NBF_A 14  fractional bits of A
//   NB_B     12  total bits of operand B;  NBF_B 11  fractional bits of B
//   NB_OUT   12  total bits of result;     NBF_OUT 11  fractional bits of result
//   Legal iff NBF_OUT <= NBF_A+NBF_B and NB_OUT-NBF_OUT <= (NB_A+NB_B)-(NBF_A+NBF_B).
//   ID_W = clog2(N_REQ) is a localparam.
// PORTS
//   i_clock      in   1            single clock, rising edge
//   i_reset      in   1            asynchronous, active-high
//   i_req_valid  in   N_REQ        request valid per requester
//   o_req_ready  out  N_REQ        one-hot grant; the transfer happens on valid&ready
//   i_req_a      in   N_REQ*NB_A   packed A operands; requester i at [i*NB_A +: NB_A]
//   i_req_b      in   N_REQ*NB_B   packed B operands
//   i_req_mode   in   N_REQ*2      00 trunc+wrap, 01 trunc+sat, 10 round+sat, 11 round+wrap
//   o_rsp_valid  out  1            result valid
//   i_rsp_ready  in   1            consumer accepts the result
//   o_rsp_id     out  ID_W         requester index of the result
//   o_rsp_data   out  NB_OUT       quantized product
//   o_rsp_sat    out  1            the result was clipped by saturation
//   o_busy       out  1            at least one pipeline stage holds a valid entry
// BEHAVIOUR
//   - Reset, asynchronous: all stage valids, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_sat, o_busy = 0.
//     The round-robin pointer is set to N_REQ-1, so requester 0 wins first.
//     In-flight work is discarded; no response for it ever appears after reset is released.
//   - advance = ~o_rsp_valid | i_rsp_ready. On !advance every stage holds and o_req_ready = 0.
//   - Arbitration: when advance=1, grant the first valid requester searching from ptr+1 with wrap.
//     o_req_ready is combinational from i_req_valid and advance, and has at most one bit set.
//     ptr updates to the granted index only on a transfer.
//     The requester holds valid, operands and mode stable until ready.
//   - Stage 1 registers the granted A, B, mode and id.
//     Stage 2 registers the signed full-res product: NB_A+NB_B bits, NBF_A+NBF_B fractional.
//     Stage 3 quantizes into the output register.
//     Latency: transfer at cycle t gives o_rsp_valid at t+3. Throughput is 1 per cycle.
//   - Quantize, with D = NBF_A+NBF_B-NBF_OUT:
//     trunc: arithmetic shift right by D (floor).
//     round: add 2^(D-1), then shift (round half up). Skip the add when D=0. The adder is one bit wider.
//     sat: if the discarded MSBs are not all equal to the result sign, clip.
//       Positive overflow clips to {0,1..1}; negative overflow clips to {1,0..0}. o_rsp_sat=1.
//     wrap: keep the low NB_OUT bits. o_rsp_sat=0.
//   - Responses leave in grant order. There is no reordering, loss or duplication under any backpressure.
//   - While o_rsp_valid & !i_rsp_ready, o_rsp_* stays bit-stable.
//   - o_busy = OR of the three stage valids.
// STRUCTURE
//   fp_mul_pkg: mode encodings (MODE_TRUNC_WRAP..MODE_ROUND_WRAP), the clog2 function,
//     and full-res width helper functions.
//   Sub-module fp_quant: combinational quantizer.
//     Inputs: full-res product, mode. Outputs: NB_OUT data, sat flag.
//     Parameterized by the same six width parameters.
//   The arbiter and pipeline stay in fp_mul_sched.
// TESTING (defaults: A Q2.14, B Q1.11, out Q1.11, D=14)
//   1. Req0 A=16'h2000, B=12'h400, mode 01, i_rsp_ready=1 -> at t+3: data 12'h200, id 0, sat 0.
//   2. A=16'h7FFF, B=12'h7FF: mode 01 -> 12'h7FF, sat 1; mode 00 -> 12'hFFD, sat 0.
//      A=16'h8000, B=12'h7FF, mode 01 -> 12'h800, sat 1.
//   3. A=16'h2000, B=12'h001: mode 10 -> 12'h001; mode 01 -> 12'h000.
//   4. All 4 requesters valid continuously -> grants 0,1,2,3,0,... one per cycle;
//      response ids follow the same sequence, 3 cycles later.
//   5. Full pipeline, i_rsp_ready=0 for 5 cycles -> o_req_ready=0 and o_rsp_* stable;
//      after release all results arrive in order, none lost or duplicated.
//   6. Reset pulse with 3 entries in flight -> o_rsp_valid=0 at once;
//      no stale response after release; the next grant goes to requester 0.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the fixed-point multiplier scheduler: quantization
// mode encodings and width helpers for the full-resolution product.
package fp_mul_pkg;

   typedef enum logic [1:0] {
      MODE_TRUNC_WRAP = 2'b00,
      MODE_TRUNC_SAT  = 2'b01,
      MODE_ROUND_SAT  = 2'b10,
      MODE_ROUND_WRAP = 2'b11
   } quant_mode_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int prod_w(input int nb_a, input int nb_b);
      return nb_a + nb_b;
   endfunction

   function automatic int prod_f(input int nbf_a, input int nbf_b);
      return nbf_a + nbf_b;
   endfunction

   function automatic logic mode_rounds(input quant_mode_e m);
      return (m == MODE_ROUND_SAT) || (m == MODE_ROUND_WRAP);
   endfunction

   function automatic logic mode_sats(input quant_mode_e m);
      return (m == MODE_TRUNC_SAT) || (m == MODE_ROUND_SAT);
   endfunction

endpackage

// File: rtl/fp_quant.sv
// Combinational quantizer: reduces the full-resolution signed product to
// NB_OUT/NBF_OUT with truncate or round-half-up, and saturate or wrap.
module fp_quant
   import fp_mul_pkg::*;
#(
   parameter int NB_A    = 16,
   parameter int NBF_A   = 14,
   parameter int NB_B    = 12,
   parameter int NBF_B   = 11,
   parameter int NB_OUT  = 12,
   parameter int NBF_OUT = 11
) (
   input  logic [prod_w(NB_A, NB_B)-1:0] prod,
   input  logic [1:0]                    mode,
   output logic [NB_OUT-1:0]             data,
   output logic                          sat
);

   localparam int PW = prod_w(NB_A, NB_B);
   localparam int D  = prod_f(NBF_A, NBF_B) - NBF_OUT;
   localparam logic [PW:0] ONE = 1;

   logic signed [PW:0] half;
   logic signed [PW:0] ext;
   logic signed [PW:0] biased;
   logic signed [PW:0] shifted;
   logic               use_round;
   logic               use_sat;
   logic               overflow;

   generate
      if (D > 0) begin : g_half
         assign half = ONE << (D - 1);
      end else begin : g_no_half
         assign half = '0;
      end
   endgenerate

   assign use_round = mode_rounds(quant_mode_e'(mode));
   assign use_sat   = mode_sats(quant_mode_e'(mode));

   always_comb begin
      ext      = {prod[PW-1], prod};
      biased   = use_round ? ext + half : ext;
      shifted  = biased >>> D;
      // The result fits only if every bit above it matches its sign bit.
      overflow = !((&shifted[PW:NB_OUT-1]) || !(|shifted[PW:NB_OUT-1]));
      data     = shifted[NB_OUT-1:0];
      sat      = 1'b0;
      if (use_sat && overflow) begin
         sat  = 1'b1;
         data = shifted[PW] ? {1'b1, {(NB_OUT-1){1'b0}}} : {1'b0, {(NB_OUT-1){1'b1}}};
      end
   end

endmodule

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one signed fixed-point multiplier among
// N_REQ requesters through a grant / multiply / quantize pipeline.
module fp_mul_sched
   import fp_mul_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int NB_A    = 16,
   parameter int NBF_A   = 14,
   parameter int NB_B    = 12,
   parameter int NBF_B   = 11,
   parameter int NB_OUT  = 12,
   parameter int NBF_OUT = 11
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic [N_REQ-1:0]        i_req_valid,
   output logic [N_REQ-1:0]        o_req_ready,
   input  logic [N_REQ*NB_A-1:0]   i_req_a,
   input  logic [N_REQ*NB_B-1:0]   i_req_b,
   input  logic [N_REQ*2-1:0]      i_req_mode,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [clog2(N_REQ)-1:0] o_rsp_id,
   output logic [NB_OUT-1:0]       o_rsp_data,
   output logic                    o_rsp_sat,
   output logic                    o_busy
);

   localparam int ID_W = clog2(N_REQ);
   localparam int PW   = prod_w(NB_A, NB_B);

   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W-1:0]   idx;
   logic              grant_any;
   logic              advance;
   logic              transfer;
   logic [NB_A-1:0]   sel_a;
   logic [NB_B-1:0]   sel_b;
   logic [1:0]        sel_mode;

   logic              s1_valid;
   logic [NB_A-1:0]   s1_a;
   logic [NB_B-1:0]   s1_b;
   logic [1:0]        s1_mode;
   logic [ID_W-1:0]   s1_id;
   logic              s2_valid;
   logic [PW-1:0]     s2_prod;
   logic [1:0]        s2_mode;
   logic [ID_W-1:0]   s2_id;
   logic [PW-1:0]     a_ext;
   logic [PW-1:0]     b_ext;
   logic [NB_OUT-1:0] q_data;
   logic              q_sat;

   assign advance = !o_rsp_valid || i_rsp_ready;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      idx       = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % N_REQ);
         if (!grant_any && i_req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = idx;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
         assign o_req_ready[gi] = advance && grant_any && (grant_id == ID_W'(gi));
      end
   endgenerate

   assign transfer = |o_req_ready;

   always_comb begin
      sel_a    = '0;
      sel_b    = '0;
      sel_mode = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_a    = i_req_a[i*NB_A +: NB_A];
            sel_b    = i_req_b[i*NB_B +: NB_B];
            sel_mode = i_req_mode[i*2 +: 2];
         end
      end
   end

   // Both operands sign-extended to the product width, so the low PW bits are the signed product.
   assign a_ext = {{NB_B{s1_a[NB_A-1]}}, s1_a};
   assign b_ext = {{NB_A{s1_b[NB_B-1]}}, s1_b};

   fp_quant #(
      .NB_A    (NB_A),
      .NBF_A   (NBF_A),
      .NB_B    (NB_B),
      .NBF_B   (NBF_B),
      .NB_OUT  (NB_OUT),
      .NBF_OUT (NBF_OUT)
   ) u_quant (
      .prod (s2_prod),
      .mode (s2_mode),
      .data (q_data),
      .sat  (q_sat)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         ptr         <= ID_W'(N_REQ - 1);
         s1_valid    <= 1'b0;
         s1_a        <= '0;
         s1_b        <= '0;
         s1_mode     <= '0;
         s1_id       <= '0;
         s2_valid    <= 1'b0;
         s2_prod     <= '0;
         s2_mode     <= '0;
         s2_id       <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_id    <= '0;
         o_rsp_data  <= '0;
         o_rsp_sat   <= 1'b0;
      end else begin
         if (transfer) ptr <= grant_id;
         if (advance) begin
            s1_valid    <= transfer;
            s1_a        <= sel_a;
            s1_b        <= sel_b;
            s1_mode     <= sel_mode;
            s1_id       <= grant_id;
            s2_valid    <= s1_valid;
            s2_prod     <= a_ext * b_ext;
            s2_mode     <= s1_mode;
            s2_id       <= s1_id;
            o_rsp_valid <= s2_valid;
            o_rsp_id    <= s2_id;
            o_rsp_data  <= q_data;
            o_rsp_sat   <= q_sat;
         end
      end
   end

   assign o_busy = s1_valid || s2_valid || o_rsp_valid;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Self-checking bench for fp_mul_sched: directed cases plus randomized
// traffic compared against an arithmetic reference model and ordered scoreboard.
module tb_fp_mul_sched;

   localparam int N      = 4;
   localparam int NB_A   = 16;
   localparam int NB_B   = 12;
   localparam int NB_OUT = 12;
   localparam int D      = 14;

   logic              i_clock = 1'b0;
   logic              i_reset = 1'b1;
   logic [N-1:0]      i_req_valid;
   logic [N-1:0]      o_req_ready;
   logic [N*NB_A-1:0] i_req_a;
   logic [N*NB_B-1:0] i_req_b;
   logic [N*2-1:0]    i_req_mode;
   logic              o_rsp_valid;
   logic              i_rsp_ready = 1'b1;
   logic [1:0]        o_rsp_id;
   logic [NB_OUT-1:0] o_rsp_data;
   logic              o_rsp_sat;
   logic              o_busy;

   logic        req_v [N];
   logic [15:0] req_a [N];
   logic [11:0] req_b [N];
   logic [1:0]  req_m [N];

   typedef struct {
      logic [1:0]  id;
      logic [11:0] d;
      logic        s;
   } exp_t;

   exp_t         q[$];
   int           checks = 0;
   int           errors = 0;
   int           m_ptr = N - 1;
   logic [N-1:0] grant_seen = '0;
   bit           hold_prev = 1'b0;
   logic [1:0]   prev_id;
   logic [11:0]  prev_d;
   logic         prev_s;

   fp_mul_sched dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_a     (i_req_a),
      .i_req_b     (i_req_b),
      .i_req_mode  (i_req_mode),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_id    (o_rsp_id),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_sat   (o_rsp_sat),
      .o_busy      (o_busy)
   );

   always #5 i_clock = ~i_clock;

   always_comb begin
      i_req_valid = '0;
      i_req_a     = '0;
      i_req_b     = '0;
      i_req_mode  = '0;
      for (int i = 0; i < N; i++) begin
         i_req_valid[i]          = req_v[i];
         i_req_a[i*NB_A +: NB_A] = req_a[i];
         i_req_b[i*NB_B +: NB_B] = req_b[i];
         i_req_mode[i*2 +: 2]    = req_m[i];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: exact product as an integer, floor-divide by 2^D, then range-clip or wrap.
   function automatic void model(input logic [15:0] a, input logic [11:0] b, input logic [1:0] mode,
                                 output logic [11:0] d, output logic s);
      longint p;
      longint r;
      p = longint'($signed(a)) * longint'($signed(b));
      r = mode[1] ? ((p + (longint'(1) <<< (D - 1))) >>> D) : (p >>> D);
      d = 12'(r);
      s = 1'b0;
      if (mode == 2'b01 || mode == 2'b10) begin
         if (r > 2047) begin
            d = 12'h7FF;
            s = 1'b1;
         end else if (r < -2048) begin
            d = 12'h800;
            s = 1'b1;
         end
      end
   endfunction

   always @(negedge i_clock) begin : mon
      int           gidx;
      logic [N-1:0] exp_g;
      exp_t         e;
      if (i_reset) begin
         q.delete();
         m_ptr      = N - 1;
         hold_prev  = 1'b0;
         grant_seen = '0;
      end else begin
         gidx  = -1;
         exp_g = '0;
         if (!o_rsp_valid || i_rsp_ready) begin
            for (int k = 1; k <= N; k++) begin
               if (gidx < 0 && req_v[(m_ptr + k) % N]) gidx = (m_ptr + k) % N;
            end
         end
         if (gidx >= 0) exp_g[gidx] = 1'b1;
         check("grant", 64'(o_req_ready), 64'(exp_g));
         check("busy", 64'(o_busy), 64'(q.size() != 0));
         if (hold_prev) begin
            check("stall_valid", 64'(o_rsp_valid), 64'(1));
            check("stall_id", 64'(o_rsp_id), 64'(prev_id));
            check("stall_data", 64'(o_rsp_data), 64'(prev_d));
            check("stall_sat", 64'(o_rsp_sat), 64'(prev_s));
         end
         if (o_rsp_valid && i_rsp_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got id %0h data %0h expected no response", o_rsp_id, o_rsp_data);
            end else begin
               e = q.pop_front();
               check("rsp_id", 64'(o_rsp_id), 64'(e.id));
               check("rsp_data", 64'(o_rsp_data), 64'(e.d));
               check("rsp_sat", 64'(o_rsp_sat), 64'(e.s));
            end
         end
         if (gidx >= 0) begin
            model(req_a[gidx], req_b[gidx], req_m[gidx], e.d, e.s);
            e.id = 2'(gidx);
            q.push_back(e);
            m_ptr = gidx;
         end
         grant_seen = o_req_ready;
         hold_prev  = o_rsp_valid && !i_rsp_ready;
         prev_id    = o_rsp_id;
         prev_d     = o_rsp_data;
         prev_s     = o_rsp_sat;
      end
   end

   function automatic logic [15:0] rand_a();
      case ($urandom_range(0, 4))
         0: return 16'h7FFF;
         1: return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [11:0] rand_b();
      case ($urandom_range(0, 4))
         0: return 12'h7FF;
         1: return 12'h800;
         default: return 12'($urandom);
      endcase
   endfunction

   // Lets pending requests be granted, retires them, and waits for an empty pipeline.
   task automatic drain();
      int n;
      bit any;
      i_rsp_ready = 1'b1;
      for (n = 0; n < 60; n++) begin
         @(posedge i_clock);
         #1;
         any = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (grant_seen[i]) req_v[i] = 1'b0;
            if (req_v[i]) any = 1'b1;
         end
         if (!any && !o_busy && q.size() == 0) break;
      end
      checks++;
      if (n >= 60) begin
         errors++;
         $display("FAIL drain_timeout: got busy %0d queued %0d expected idle", o_busy, q.size());
      end
   endtask

   task automatic single(input int id, input logic [15:0] a, input logic [11:0] b, input logic [1:0] mode,
                         input logic [11:0] exp_d, input logic exp_s);
      int lat;
      @(posedge i_clock);
      #1;
      i_rsp_ready = 1'b1;
      req_v[id]   = 1'b1;
      req_a[id]   = a;
      req_b[id]   = b;
      req_m[id]   = mode;
      @(negedge i_clock);
      check("single_grant", 64'(o_req_ready), 64'(1) << id);
      @(posedge i_clock);
      #1;
      req_v[id] = 1'b0;
      lat = 0;
      do begin
         @(negedge i_clock);
         lat++;
      end while (!o_rsp_valid && lat < 10);
      check("single_latency", 64'(lat), 64'(3));
      check("single_id", 64'(o_rsp_id), 64'(id));
      check("single_data", 64'(o_rsp_data), 64'(exp_d));
      check("single_sat", 64'(o_rsp_sat), 64'(exp_s));
   endtask

   task automatic all_valid();
      for (int i = 0; i < N; i++) begin
         req_v[i] = 1'b1;
         req_a[i] = 16'h1000 + 16'(i * 16'h0C35);
         req_b[i] = 12'h3A0 - 12'(i * 12'h111);
         req_m[i] = 2'(i);
      end
   endtask

   initial begin
      logic [11:0] snap_d;
      logic [1:0]  snap_id;
      for (int i = 0; i < N; i++) begin
         req_v[i] = 1'b0;
         req_a[i] = '0;
         req_b[i] = '0;
         req_m[i] = '0;
      end
      #1;
      check("rst_valid", 64'(o_rsp_valid), 64'(0));
      check("rst_id", 64'(o_rsp_id), 64'(0));
      check("rst_data", 64'(o_rsp_data), 64'(0));
      check("rst_sat", 64'(o_rsp_sat), 64'(0));
      check("rst_busy", 64'(o_busy), 64'(0));
      repeat (2) @(posedge i_clock);
      #1;
      i_reset = 1'b0;

      single(0, 16'h2000, 12'h400, 2'b01, 12'h200, 1'b0);
      single(1, 16'h7FFF, 12'h7FF, 2'b01, 12'h7FF, 1'b1);
      single(2, 16'h7FFF, 12'h7FF, 2'b00, 12'hFFD, 1'b0);
      single(1, 16'h8000, 12'h7FF, 2'b01, 12'h800, 1'b1);
      single(2, 16'h2000, 12'h001, 2'b10, 12'h001, 1'b0);
      single(0, 16'h2000, 12'h001, 2'b01, 12'h000, 1'b0);
      single(3, 16'h7FFF, 12'h7FF, 2'b11, 12'hFFE, 1'b0);
      drain();

      // Continuous contention: grants rotate 0..3, ids follow three cycles later.
      @(posedge i_clock);
      #1;
      all_valid();
      for (int c = 0; c < 12; c++) begin
         @(negedge i_clock);
         check("rr_grant", 64'(o_req_ready), 64'(1) << (c % N));
         if (c >= 3) begin
            check("rr_rsp_valid", 64'(o_rsp_valid), 64'(1));
            check("rr_rsp_id", 64'(o_rsp_id), 64'((c - 3) % N));
         end
      end
      drain();

      // Backpressure on a full pipeline.
      @(posedge i_clock);
      #1;
      all_valid();
      repeat (4) @(posedge i_clock);
      #1;
      i_rsp_ready = 1'b0;
      @(negedge i_clock);
      snap_d  = o_rsp_data;
      snap_id = o_rsp_id;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge i_clock);
         check("bp_ready", 64'(o_req_ready), 64'(0));
         check("bp_valid", 64'(o_rsp_valid), 64'(1));
         check("bp_data", 64'(o_rsp_data), 64'(snap_d));
         check("bp_id", 64'(o_rsp_id), 64'(snap_id));
      end
      @(posedge i_clock);
      #1;
      i_rsp_ready = 1'b1;
      drain();

      // Randomized traffic with random consumer backpressure.
      for (int c = 0; c < 3000; c++) begin
         @(posedge i_clock);
         #1;
         for (int i = 0; i < N; i++) begin
            if (!req_v[i] || grant_seen[i]) begin
               req_v[i] = ($urandom_range(0, 3) != 0);
               req_a[i] = rand_a();
               req_b[i] = rand_b();
               req_m[i] = 2'($urandom_range(0, 3));
            end
         end
         i_rsp_ready = ($urandom_range(0, 3) != 0);
      end
      drain();

      // Reset with three entries in flight.
      @(posedge i_clock);
      #1;
      all_valid();
      repeat (3) @(posedge i_clock);
      #2;
      i_reset = 1'b1;
      #1;
      check("flush_valid", 64'(o_rsp_valid), 64'(0));
      check("flush_busy", 64'(o_busy), 64'(0));
      @(posedge i_clock);
      #1;
      i_reset = 1'b0;
      @(negedge i_clock);
      check("flush_first_grant", 64'(o_req_ready), 64'(1));
      drain();
      check("leftover", 64'(q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
